// File: rtl/var_bw_mul_acc.sv
// Accumulator behind a variable bit-width multiplier: sums len products either as
// one 40-bit total or as two independent 20-bit lane totals, with a sticky overflow flag.
module var_bw_mul_acc #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             para_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [39:0]      acc,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [LEN_W-1:0] cnt_q;
    logic             mode_q;
    logic [39:0]      acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, out_valid_q, busy_q;
    logic [40:0]      full_sum;
    logic [20:0]      lo_sum, hi_sum;
    logic             beat;

    assign beat = in_valid && in_ready_q;

    // Bit 40 / bit 20 of each sum is the carry out that feeds the overflow flag.
    // NOTE: every branch assigns acc_d and ovf_d, so this block stays purely combinational.
    always_comb begin
        full_sum = {1'b0, acc_q} + {9'd0, p};
        lo_sum   = {1'b0, acc_q[19:0]}  + {5'd0, p[15:0]};
        hi_sum   = {1'b0, acc_q[39:20]} + {5'd0, p[31:16]};
        if (mode_q) begin
            acc_d = {hi_sum[19:0], lo_sum[19:0]};
            ovf_d = ovf_q | hi_sum[20] | lo_sum[20];
        end else begin
            acc_d = full_sum[39:0];
            ovf_d = ovf_q | full_sum[40];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q <= para_mode;
                        cnt_q  <= len;
                        acc_q  <= '0;
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (len != '0) begin
                            state_q    <= ACC;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == LEN_W'(1)) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here, even on the handshake cycle
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign acc       = acc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_var_bw_mul_acc.sv
// Bench for var_bw_mul_acc: directed table of runs, hand-written hold/reset sequences,
// and randomized runs checked against an arithmetic model of lane and full sums.
module tb_var_bw_mul_acc;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             para_mode = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      p = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [39:0]      acc;
    logic             ovf;
    logic             busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] beat_q[$];

    var_bw_mul_acc #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .para_mode (para_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p         (p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        para;
        int          n;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [39:0] e_acc;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer sums of the whole run, then reduced modulo the lane size.
    function automatic void model(input logic para, output logic [39:0] e_acc, output logic e_ovf);
        longint unsigned s, lo, hi;
        s = 0; lo = 0; hi = 0;
        foreach (beat_q[i]) begin
            s  += longint'(beat_q[i]);
            lo += longint'(beat_q[i] & 32'h0000_FFFF);
            hi += longint'(beat_q[i] >> 16);
        end
        if (para) begin
            e_acc = {20'(hi % 64'h10_0000), 20'(lo % 64'h10_0000)};
            e_ovf = (lo >= 64'h10_0000) || (hi >= 64'h10_0000);
        end else begin
            e_acc = 40'(s % 64'h100_0000_0000);
            e_ovf = (s >= 64'h100_0000_0000);
        end
    endfunction

    // One complete run using beat_q as the products; all driving and sampling at negedge.
    task automatic run_check(input string name, input logic para, input int n, input int bubble_pct,
                             input int hold, input logic poke, input logic [39:0] e_acc,
                             input logic e_ovf);
        int idx;
        int cyc;
        @(negedge clk);
        start = 1'b1; len = LEN_W'(n); para_mode = para;
        @(negedge clk);
        start = 1'b0; len = LEN_W'($urandom); para_mode = 1'($urandom);
        check({name, " busy"}, 64'(busy), 64'd1);
        idx = 0; cyc = 0;
        while (idx < n && cyc < 1000) begin
            in_valid = ($urandom_range(99) >= 32'(bubble_pct));
            p = in_valid ? beat_q[idx] : $urandom;
            if (in_valid && in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        if (idx < n) check({name, " beats accepted before timeout"}, 64'(idx), 64'(n));
        check({name, " out_valid"}, 64'(out_valid), 64'd1);
        check({name, " in_ready in DONE"}, 64'(in_ready), 64'd0);
        check({name, " acc"}, 64'(acc), 64'(e_acc));
        check({name, " ovf"}, 64'(ovf), 64'(e_ovf));
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0; start = poke; len = 8'd5; in_valid = 1'b1; p = $urandom;
            @(negedge clk);
            check({name, " hold out_valid"}, 64'(out_valid), 64'd1);
            check({name, " hold acc"}, 64'(acc), 64'(e_acc));
            check({name, " hold ovf"}, 64'(ovf), 64'(e_ovf));
        end
        out_ready = 1'b1; start = poke; len = 8'd5; in_valid = 1'b1; p = $urandom;
        @(negedge clk);
        out_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
        check({name, " out_valid after handshake"}, 64'(out_valid), 64'd0);
        check({name, " busy after handshake"}, 64'(busy), 64'd0);
        in_valid = 1'b1; p = $urandom;
        @(negedge clk);
        in_valid = 1'b0;
        check({name, " idle acc retained"}, 64'(acc), 64'(e_acc));
        check({name, " idle ovf retained"}, 64'(ovf), 64'(e_ovf));
        check({name, " idle in_ready"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        logic [39:0] m_acc;
        logic        m_ovf;
        logic        para;
        int          n;

        vecs[0] = '{"full_3x_ffff",   1'b0,   3, 32'h0000_FFFF, 32'h0000_FFFF, 40'h00_0002_FFFD, 1'b0};
        vecs[1] = '{"para_no_xlane",  1'b1,   2, 32'hFFFF_0001, 32'hFFFF_0002, {20'h1FFFE, 20'h00003}, 1'b0};
        vecs[2] = '{"para_wrap_17",   1'b1,  17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {20'h0FFEF, 20'h0FFEF}, 1'b1};
        vecs[3] = '{"para_edge_16",   1'b1,  16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {20'hFFFF0, 20'hFFFF0}, 1'b0};
        vecs[4] = '{"len_zero",       1'b0,   0, 32'h0000_0000, 32'h0000_0000, 40'h0, 1'b0};
        vecs[5] = '{"full_len_max",   1'b0, 255, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 40'hFE_FFFF_FF01, 1'b0};

        #2 rst = 1'b1;
        #2;
        check("reset acc", 64'(acc), 64'd0);
        check("reset ovf", 64'(ovf), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[v]) begin
            beat_q.delete();
            for (int i = 0; i < vecs[v].n; i++) beat_q.push_back(i == 0 ? vecs[v].p0 : vecs[v].p1);
            run_check(vecs[v].name, vecs[v].para, vecs[v].n, 0, 0, 1'b0, vecs[v].e_acc, vecs[v].e_ovf);
        end

        // Bubbles on input, consumer stalls three cycles, start pokes while in DONE.
        beat_q = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001};
        run_check("full_bubbles_hold", 1'b0, 4, 50, 3, 1'b1, 40'h01_9234_5678, 1'b0);

        // Abort after two of four beats; outputs must drop without waiting for a clock edge.
        beat_q = '{32'h1111_1111, 32'h2222_2222};
        @(negedge clk);
        start = 1'b1; len = 8'd4; para_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        foreach (beat_q[i]) begin
            in_valid = 1'b1; p = beat_q[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("abort partial acc", 64'(acc), 64'h3333_3333);
        check("abort busy before rst", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("abort acc", 64'(acc), 64'd0);
        check("abort ovf", 64'(ovf), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort in_ready", 64'(in_ready), 64'd0);
        check("abort out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        beat_q = '{32'h0000_0005};
        run_check("rerun_after_abort", 1'b0, 1, 0, 0, 1'b0, 40'd5, 1'b0);

        for (int r = 0; r < 24; r++) begin
            para = 1'($urandom_range(1));
            n = $urandom_range(0, 24);
            beat_q.delete();
            for (int i = 0; i < n; i++)
                beat_q.push_back(($urandom_range(3) == 0) ? (32'hF000_F000 | $urandom) : $urandom);
            model(para, m_acc, m_ovf);
            run_check($sformatf("rand%0d", r), para, n, 30, $urandom_range(0, 2),
                      1'($urandom_range(1)), m_acc, m_ovf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/var_bw_mul_acc.md
VAR_BW_MUL_ACC -- requirements
Module: var_bw_mul_acc

Interface
REQ-001 SHALL have parameter LEN_W, default 8, meaning width of the term-count input.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin an accumulation run.
REQ-005 SHALL have port len  input  LEN_W  number of products in the run, sampled with start.
REQ-006 SHALL have port para_mode  input  1  mode sampled with start; 1 = two 16-bit lane products, 0 = one 32-bit product.
REQ-007 SHALL have port in_valid  input  1  product p is valid.
REQ-008 SHALL have port in_ready  output  1  block accepts p this cycle.
REQ-009 SHALL have port p  input  32  product from the upstream variable bit-width multiplier; para layout {hi[31:16], lo[15:0]}.
REQ-010 SHALL have port out_valid  output  1  result is valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port acc  output  40  result; full mode = 40-bit sum; para mode = {hi_sum[39:20], lo_sum[19:0]}.
REQ-013 SHALL have port ovf  output  1  sticky overflow flag for the run, valid with out_valid.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, ACC, DONE.
REQ-016 IDLE: start=1 SHALL latch para_mode and len, clear acc and ovf; next state ACC if len!=0, else DONE.
REQ-017 start SHALL be ignored in ACC and DONE.
REQ-018 in_ready SHALL equal 1 only in ACC; a beat is accepted when in_valid && in_ready.
REQ-019 Full mode: each accepted beat SHALL add zero-extended p[31:0] to acc, modulo 2^40; carry out of bit 39 SHALL set ovf.
REQ-020 Para mode: each beat SHALL add zero-extended p[15:0] to acc[19:0] and p[31:16] to acc[39:20], each modulo 2^20, with no carry between lanes; carry out of either lane SHALL set ovf.
REQ-021 A down-counter loaded with len SHALL decrement per accepted beat; the beat that brings it to 0 SHALL move state to DONE.
REQ-022 Cycles with in_valid=0 in ACC SHALL leave acc, counter and state unchanged (bubbles allowed).
REQ-023 out_valid SHALL be 1 exactly in DONE; acc and ovf SHALL be stable while out_valid=1.
REQ-024 Latency: out_valid SHALL rise in the cycle after the final beat is accepted (one cycle after start when len=0).
REQ-025 DONE with out_ready=1 SHALL return to IDLE next cycle; acc and ovf SHALL retain last values in IDLE until next start.
REQ-026 start in the same cycle as DONE handshake SHALL be ignored (block not yet IDLE).
REQ-027 in_valid outside ACC SHALL be ignored with no state change.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, acc=0, ovf=0, counter=0, latched mode=0, in_ready=0, out_valid=0, busy=0, including mid-run.
REQ-029 After rst deasserts, the first start SHALL begin a clean run with no residue from an aborted run.

Verification
REQ-030 Full mode, len=3, p=32'h0000_FFFF x3 back-to-back -> out_valid one cycle after third beat, acc=40'h00_0002_FFFD, ovf=0.
REQ-031 Para mode, len=2, p=32'hFFFF_0001 then 32'hFFFF_0002 -> acc={20'h1FFFE, 20'h00003}, ovf=0, no carry lo->hi.
REQ-032 Para mode, len=17, p=32'hFFFF_FFFF each -> lane wrap, ovf=1, acc={20'h0FFEF,20'h0FFEF}.
REQ-033 len=0 start -> out_valid next cycle, acc=0, in_ready never asserted.
REQ-034 Full mode len=4 with in_valid bubbles and out_ready held 0 three cycles in DONE -> correct sum held stable, return to IDLE one cycle after out_ready=1; start during DONE ignored.
REQ-035 rst pulse after 2 of 4 beats -> all outputs 0 immediately; new run len=1 p=32'h0000_0005 -> acc=5, ovf=0.
